// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared write-back types and register-file geometry for the write-port arbiter.
package wb_pkg;

    localparam int REG_AW        = 5;
    localparam int DATA_W        = 32;
    localparam int NUM_ARCH_REGS = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: the search starts one past ptr, so ptr holds the last winner.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with RAW pending-write scoreboard.
// Optional per-requester stall counters are enabled by defining WB_PERF_CNT_EN.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [REG_AW*NUM_REQ-1:0]   req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data,
    input  logic                        rsv_valid,
    input  logic [REG_AW-1:0]           rsv_addr,
    output logic                        rsv_ready,
    output logic                        rf_we,
    output logic [REG_AW-1:0]           rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
`ifdef WB_PERF_CNT_EN
    input  logic                        perf_clr,
    output logic [16*NUM_REQ-1:0]       perf_stall,
`endif
    output logic [NUM_ARCH_REGS-1:0]    busy_mask
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_req_t                 reqs [NUM_REQ];
    wb_req_t                 win;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           win_idx;
    logic                    win_any;
    logic [CNT_W-1:0]        pending_cnt [NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] inc_vec;
    logic [NUM_ARCH_REGS-1:0] dec_vec;
    logic                    rsv_take;
    logic                    wb_clear;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign reqs[i] = {req_addr[REG_AW*i +: REG_AW], req_data[DATA_W*i +: DATA_W]};
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (req_ready),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign win = reqs[win_idx];

    assign rsv_ready = (rsv_addr == ZERO_REG) || (pending_cnt[rsv_addr] != CNT_MAX);
    assign rsv_take  = rsv_valid && rsv_ready && (rsv_addr != ZERO_REG);
    assign wb_clear  = win_any && (win.addr != ZERO_REG);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (rsv_take) inc_vec[rsv_addr] = 1'b1;
        if (wb_clear) dec_vec[win.addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rr_ptr   <= PW'(NUM_REQ - 1);
        end else if (win_any) begin
            rf_we    <= (win.addr != ZERO_REG);
            rf_waddr <= win.addr;
            rf_wdata <= win.data;
            rr_ptr   <= win_idx;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Reserve and clear of the same register cancel; clearing an empty counter holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) pending_cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_ARCH_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    pending_cnt[r] <= pending_cnt[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && pending_cnt[r] != '0)
                    pending_cnt[r] <= pending_cnt[r] - 1'b1;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 0; r < NUM_ARCH_REGS; r++)
            busy_mask[r] = (pending_cnt[r] != '0);
    end

`ifdef WB_PERF_CNT_EN
    logic [15:0] stall_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) stall_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (perf_clr)
                    stall_cnt[i] <= '0;
                else if (req_valid[i] && !req_ready[i] && stall_cnt[i] != '1)
                    stall_cnt[i] <= stall_cnt[i] + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        assign perf_stall[16*i +: 16] = stall_cnt[i];
    end
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (!rst_n)
            req_valid[i] && !req_ready[i] |=> req_valid[i]);
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

    a_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        wb_clear |-> (pending_cnt[win.addr] != '0) || (rsv_take && rsv_addr == win.addr));

endmodule
